// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer and the cell array it feeds.
package program_sequencer_pkg;

  localparam int unsigned PC_WIDTH_DEF    = 12;
  localparam int unsigned INSTR_WIDTH_DEF = 16;
  localparam int unsigned GEN_WIDTH_DEF   = 16;

  // Instruction word layout as decoded by the cell array
  localparam int unsigned OPCODE_MSB  = 15;
  localparam int unsigned OPCODE_LSB  = 12;
  localparam int unsigned OPCODE_W    = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int unsigned OPERAND_MSB = 11;
  localparam int unsigned OPERAND_LSB = 0;

  localparam logic [OPCODE_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_LOAD  = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_STORE = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_ALU   = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_SHIFT = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RUN        = 2'd1,
    ST_WAIT_FRAME = 2'd2
  } seq_state_e;

endpackage

// File: rtl/program_sequencer_if.sv
// Load, control, broadcast and status signals of the program sequencer.
interface program_sequencer_if
  import program_sequencer_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = PC_WIDTH_DEF,
  parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int unsigned GEN_WIDTH   = GEN_WIDTH_DEF
) ();

  logic                   load_valid;
  logic                   load_ready;
  logic [PC_WIDTH-1:0]    load_addr;
  logic [INSTR_WIDTH-1:0] load_data;
  logic                   start;
  logic [PC_WIDTH-1:0]    last_pc;
  logic [GEN_WIDTH-1:0]   gen_total;
  logic                   frame_sync_en;
  logic                   frame_tick;
  logic                   abort;
  logic [PC_WIDTH-1:0]    program_counter;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   execution_enable;
  logic                   busy;
  logic                   done;
  logic [GEN_WIDTH-1:0]   gen_count;

  modport master (
    output load_valid, load_addr, load_data, start, last_pc, gen_total,
           frame_sync_en, frame_tick, abort,
    input  load_ready, program_counter, instruction, execution_enable,
           busy, done, gen_count
  );

  modport slave (
    input  load_valid, load_addr, load_data, start, last_pc, gen_total,
           frame_sync_en, frame_tick, abort,
    output load_ready, program_counter, instruction, execution_enable,
           busy, done, gen_count
  );

endinterface

// File: rtl/program_sequencer_prog_ram.sv
// Program memory: one write port, one synchronous read port.
// The array itself is never reset so a loaded program survives rst.
module prog_ram #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register doubles as the broadcast instruction register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/program_sequencer.sv
// Fetches a stored program and broadcasts it to the cell array for a
// programmed number of generations, optionally paced by frame ticks.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = PC_WIDTH_DEF,
  parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int unsigned GEN_WIDTH   = GEN_WIDTH_DEF
) (
  input logic                clk,
  input logic                rst,
  program_sequencer_if.slave bus
);

  seq_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]  last_pc_q;
  logic [GEN_WIDTH-1:0] gen_total_q;
  logic [GEN_WIDTH-1:0] gen_count_q, gen_count_d, gen_inc_c;
  logic                 wait_armed_q;
  logic                 fetch_c, capture_c, done_d, write_c;
  logic [PC_WIDTH-1:0]  pc_q;
  logic                 exec_en_q, done_q, busy_q, load_ready_q;

  // Next state and next register values
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    gen_count_d = gen_count_q;
    fetch_c     = 1'b0;
    capture_c   = 1'b0;
    done_d      = 1'b0;
    gen_inc_c   = (gen_count_q == '1) ? gen_count_q : gen_count_q + GEN_WIDTH'(1);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.gen_total == '0) begin
            done_d = 1'b1;
          end else begin
            capture_c   = 1'b1;
            gen_count_d = '0;
            fetch_pc_d  = '0;
            state_d     = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          fetch_c = 1'b1;
          if (fetch_pc_q == last_pc_q) begin
            fetch_pc_d  = '0;
            gen_count_d = gen_inc_c;
            if (gen_inc_c == gen_total_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else if (bus.frame_sync_en) begin
              state_d = ST_WAIT_FRAME;
            end
          end else begin
            fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
          end
        end
      end
      ST_WAIT_FRAME: begin
        // A tick in the first waiting cycle belongs to the previous frame
        if (bus.abort)                            state_d = ST_IDLE;
        else if (bus.frame_tick && wait_armed_q) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q   <= '0;
      last_pc_q    <= '0;
      gen_total_q  <= '0;
      gen_count_q  <= '0;
      wait_armed_q <= 1'b0;
      pc_q         <= '0;
      exec_en_q    <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      gen_count_q  <= gen_count_d;
      if (capture_c) begin
        last_pc_q   <= bus.last_pc;
        gen_total_q <= bus.gen_total;
      end
      wait_armed_q <= (state_q == ST_WAIT_FRAME);
      if (fetch_c) pc_q <= fetch_pc_q;
      exec_en_q    <= fetch_c;
      done_q       <= done_d;
      busy_q       <= (state_d != ST_IDLE);
      load_ready_q <= (state_d == ST_IDLE);
    end
  end

  assign write_c = bus.load_valid && load_ready_q && (state_q == ST_IDLE);

  prog_ram #(
    .ADDR_WIDTH(PC_WIDTH),
    .DATA_WIDTH(INSTR_WIDTH)
  ) u_prog_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (write_c),
    .waddr(bus.load_addr),
    .wdata(bus.load_data),
    .re   (fetch_c),
    .raddr(fetch_pc_q),
    .rdata(bus.instruction)
  );

  assign bus.program_counter  = pc_q;
  assign bus.execution_enable = exec_en_q;
  assign bus.done             = done_q;
  assign bus.busy             = busy_q;
  assign bus.load_ready       = load_ready_q;
  assign bus.gen_count        = gen_count_q;

endmodule
